// File: rtl/data_path_pkg.sv
// Shared definitions for the data path: word width and ALU operation encodings.
package data_path_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHRA = 5'b01000,
    OP_SHL  = 5'b01001,
    OP_ROR  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010,
    OP_INC  = 5'b11111
  } alu_op_e;

endpackage

// File: rtl/register32.sv
// Generic data-path register with synchronous active-low clear and load enable.
module register32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clear)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/data_path.sv
// Single-bus processor data path: register file, special registers, bus mux and ALU.
module data_path
  import data_path_pkg::*;
(
  input  logic              Clock,
  input  logic              clear,
  input  logic              Read,
  input  logic [4:0]        op,
  input  logic [WORD_W-1:0] Mdatain,
  input  logic              R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic              R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic              HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout,
  input  logic              R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic              R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic              HIin, LOin, ZHighin, Zlowin, InPC, MDRin, InPortin, Yin,
  output logic [WORD_W-1:0] BusOut,
  output logic [WORD_W-1:0] mdrData,
  output logic [WORD_W-1:0] BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3,
  output logic [WORD_W-1:0] BusMuxInR4, BusMuxInR5, BusMuxInR6, BusMuxInR7,
  output logic [WORD_W-1:0] BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
  output logic [WORD_W-1:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
  output logic [WORD_W-1:0] BusMuxInZhigh,
  output logic [WORD_W-1:0] BusMuxInZlow,
  output logic [WORD_W-1:0] BusMuxInPCout,
  output logic [WORD_W-1:0] BusMuxInInPortout,
  output logic [WORD_W-1:0] BusMuxInYout,
  output logic [WORD_W-1:0] BusMuxInHI,
  output logic [WORD_W-1:0] BusMuxInLO
);

  logic [15:0]       r_out, r_in;
  logic [WORD_W-1:0] r_q [16];
  logic [WORD_W-1:0] hi_q, lo_q, zhi_q, zlo_q, pc_q, mdr_q, inport_q, y_q;
  logic [WORD_W-1:0] bus, mdr_d, alu_hi, alu_lo;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  for (genvar i = 0; i < 16; i++) begin : g_gpr
    register32 #(.DATA_W(WORD_W)) u_r (
      .clk(Clock), .clear(clear), .load(r_in[i]), .d(bus), .q(r_q[i])
    );
  end

  assign mdr_d = Read ? Mdatain : bus;

  register32 #(.DATA_W(WORD_W)) u_hi     (.clk(Clock), .clear(clear), .load(HIin),     .d(bus),    .q(hi_q));
  register32 #(.DATA_W(WORD_W)) u_lo     (.clk(Clock), .clear(clear), .load(LOin),     .d(bus),    .q(lo_q));
  register32 #(.DATA_W(WORD_W)) u_zhigh  (.clk(Clock), .clear(clear), .load(ZHighin),  .d(alu_hi), .q(zhi_q));
  register32 #(.DATA_W(WORD_W)) u_zlow   (.clk(Clock), .clear(clear), .load(Zlowin),   .d(alu_lo), .q(zlo_q));
  register32 #(.DATA_W(WORD_W)) u_pc     (.clk(Clock), .clear(clear), .load(InPC),     .d(bus),    .q(pc_q));
  register32 #(.DATA_W(WORD_W)) u_mdr    (.clk(Clock), .clear(clear), .load(MDRin),    .d(mdr_d),  .q(mdr_q));
  register32 #(.DATA_W(WORD_W)) u_inport (.clk(Clock), .clear(clear), .load(InPortin), .d(bus),    .q(inport_q));
  register32 #(.DATA_W(WORD_W)) u_y      (.clk(Clock), .clear(clear), .load(Yin),      .d(bus),    .q(y_q));

  // Checked from lowest to highest priority so the last match (R0 first) wins.
  always_comb begin
    bus = '0;
    if (Yout)      bus = y_q;
    if (InPortout) bus = inport_q;
    if (MDRout)    bus = mdr_q;
    if (PCout)     bus = pc_q;
    if (Zlowout)   bus = zlo_q;
    if (Zhighout)  bus = zhi_q;
    if (LOout)     bus = lo_q;
    if (HIOut)     bus = hi_q;
    for (int i = 15; i >= 0; i--)
      if (r_out[i]) bus = r_q[i];
  end

  logic signed [WORD_W-1:0]   a_s;
  logic signed [2*WORD_W-1:0] a_ext, b_ext, prod;
  logic [4:0]                 shamt;

  assign a_s   = y_q;
  assign a_ext = {{WORD_W{y_q[WORD_W-1]}}, y_q};
  assign b_ext = {{WORD_W{bus[WORD_W-1]}}, bus};
  assign prod  = a_ext * b_ext;
  assign shamt = bus[4:0];

  // Rotates use the complementary shift (-shamt mod 32); at shamt=0 both halves equal A.
  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    case (op)
      OP_ADD:  alu_lo = y_q + bus;
      OP_SUB:  alu_lo = y_q - bus;
      OP_AND:  alu_lo = y_q & bus;
      OP_OR:   alu_lo = y_q | bus;
      OP_SHR:  alu_lo = y_q >> shamt;
      OP_SHRA: alu_lo = a_s >>> shamt;
      OP_SHL:  alu_lo = y_q << shamt;
      OP_ROR:  alu_lo = (y_q >> shamt) | (y_q << (5'd0 - shamt));
      OP_ROL:  alu_lo = (y_q << shamt) | (y_q >> (5'd0 - shamt));
      OP_MUL:  {alu_hi, alu_lo} = prod;
      OP_NEG:  alu_lo = '0 - bus;
      OP_NOT:  alu_lo = ~bus;
      OP_INC:  alu_lo = bus + 1'b1;
      default: begin
        alu_hi = '0;
        alu_lo = '0;
      end
    endcase
  end

  assign BusOut  = bus;
  assign mdrData = mdr_q;

  assign BusMuxInR0  = r_q[0];
  assign BusMuxInR1  = r_q[1];
  assign BusMuxInR2  = r_q[2];
  assign BusMuxInR3  = r_q[3];
  assign BusMuxInR4  = r_q[4];
  assign BusMuxInR5  = r_q[5];
  assign BusMuxInR6  = r_q[6];
  assign BusMuxInR7  = r_q[7];
  assign BusMuxInR8  = r_q[8];
  assign BusMuxInR9  = r_q[9];
  assign BusMuxInR10 = r_q[10];
  assign BusMuxInR11 = r_q[11];
  assign BusMuxInR12 = r_q[12];
  assign BusMuxInR13 = r_q[13];
  assign BusMuxInR14 = r_q[14];
  assign BusMuxInR15 = r_q[15];

  assign BusMuxInZhigh     = zhi_q;
  assign BusMuxInZlow      = zlo_q;
  assign BusMuxInPCout     = pc_q;
  assign BusMuxInInPortout = inport_q;
  assign BusMuxInYout      = y_q;
  assign BusMuxInHI        = hi_q;
  assign BusMuxInLO        = lo_q;

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path: bus priority, register transfers, ALU ops, clear.
module tb_data_path;

  logic        Clock = 1'b0;
  logic        clear, Read;
  logic [4:0]  op;
  logic [31:0] Mdatain;
  logic [15:0] r_out, r_in;
  logic        HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout;
  logic        HIin, LOin, ZHighin, Zlowin, InPC, MDRin, InPortin, Yin;
  logic [31:0] BusOut, mdrData;
  logic [31:0] r_mon [16];
  logic [31:0] zhi_mon, zlo_mon, pc_mon, inport_mon, y_mon, hi_mon, lo_mon;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  data_path dut (
    .Clock(Clock), .clear(clear), .Read(Read), .op(op), .Mdatain(Mdatain),
    .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
    .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
    .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .HIOut(HIOut), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Yout(Yout),
    .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
    .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
    .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin), .Zlowin(Zlowin),
    .InPC(InPC), .MDRin(MDRin), .InPortin(InPortin), .Yin(Yin),
    .BusOut(BusOut), .mdrData(mdrData),
    .BusMuxInR0(r_mon[0]), .BusMuxInR1(r_mon[1]), .BusMuxInR2(r_mon[2]), .BusMuxInR3(r_mon[3]),
    .BusMuxInR4(r_mon[4]), .BusMuxInR5(r_mon[5]), .BusMuxInR6(r_mon[6]), .BusMuxInR7(r_mon[7]),
    .BusMuxInR8(r_mon[8]), .BusMuxInR9(r_mon[9]), .BusMuxInR10(r_mon[10]), .BusMuxInR11(r_mon[11]),
    .BusMuxInR12(r_mon[12]), .BusMuxInR13(r_mon[13]), .BusMuxInR14(r_mon[14]), .BusMuxInR15(r_mon[15]),
    .BusMuxInZhigh(zhi_mon), .BusMuxInZlow(zlo_mon), .BusMuxInPCout(pc_mon),
    .BusMuxInInPortout(inport_mon), .BusMuxInYout(y_mon), .BusMuxInHI(hi_mon), .BusMuxInLO(lo_mon)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Read = 1'b0; r_out = '0; r_in = '0;
    HIOut = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0; InPortout = 0; Yout = 0;
    HIin = 0; LOin = 0; ZHighin = 0; Zlowin = 0; InPC = 0; MDRin = 0; InPortin = 0; Yin = 0;
  endtask

  task automatic set_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
    idle();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] v);
    set_mdr(v);
    MDRout = 1'b1; r_in[idx] = 1'b1;
    tick();
    idle();
  endtask

  task automatic load_y(input logic [31:0] v);
    set_mdr(v);
    MDRout = 1'b1; Yin = 1'b1;
    tick();
    idle();
  endtask

  task automatic run_alu(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    load_y(a);
    set_mdr(b);
    MDRout = 1'b1; op = code; ZHighin = 1'b1; Zlowin = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    op = 5'b0; Mdatain = 32'h0; clear = 1'b0;
    tick();
    check("reset_r0", r_mon[0], 32'h0);
    check("reset_zlow", zlo_mon, 32'h0);
    check("reset_mdr", mdrData, 32'h0);
    check("reset_bus", BusOut, 32'h0);
    clear = 1'b1;

    // Memory read into MDR, then transfer to R2
    set_mdr(32'h12);
    MDRout = 1'b1; r_in[2] = 1'b1;
    tick();
    idle();
    check("mdr_to_r2", r_mon[2], 32'h12);
    check("mdr_data", mdrData, 32'h12);

    // AND through Y and Zlow, result moved to R1
    load_reg(3, 32'h14);
    r_out[2] = 1'b1; Yin = 1'b1;
    tick(); idle();
    r_out[3] = 1'b1; op = 5'b00101; Zlowin = 1'b1;
    #1 check("bus_r3", BusOut, 32'h14);
    tick(); idle();
    Zlowout = 1'b1; r_in[1] = 1'b1;
    tick(); idle();
    check("and_zlow", zlo_mon, 32'h10);
    check("and_r1", r_mon[1], 32'h10);
    check("and_zhigh", zhi_mon, 32'h0);

    // Signed multiply -1 * 2
    run_alu(5'b01111, 32'hFFFFFFFF, 32'h2);
    check("mul_hi", zhi_mon, 32'hFFFFFFFF);
    check("mul_lo", zlo_mon, 32'hFFFFFFFE);
    run_alu(5'b01111, 32'hFFFFFFFD, 32'h7);
    check("mul2_hi", zhi_mon, 32'hFFFFFFFF);
    check("mul2_lo", zlo_mon, 32'hFFFFFFEB);

    // Rotate / shift of R5 by 1 with Y sourced from R5
    load_reg(5, 32'h80000001);
    r_out[5] = 1'b1; Yin = 1'b1;
    tick(); idle();
    set_mdr(32'h1);
    MDRout = 1'b1; op = 5'b01010; Zlowin = 1'b1; ZHighin = 1'b1;
    tick(); idle();
    check("ror1", zlo_mon, 32'hC0000000);
    check("ror1_hi", zhi_mon, 32'h0);
    MDRout = 1'b1; op = 5'b01000; Zlowin = 1'b1;
    tick(); idle();
    check("shra1", zlo_mon, 32'hC0000000);
    MDRout = 1'b1; op = 5'b00111; Zlowin = 1'b1;
    tick(); idle();
    check("shr1", zlo_mon, 32'h40000000);

    run_alu(5'b00011, 32'hFFFFFFFF, 32'h2);
    check("add_wrap", zlo_mon, 32'h1);
    check("add_hi", zhi_mon, 32'h0);
    run_alu(5'b00100, 32'h3, 32'h5);
    check("sub", zlo_mon, 32'hFFFFFFFE);
    run_alu(5'b00110, 32'hF0, 32'h0F);
    check("or", zlo_mon, 32'hFF);
    run_alu(5'b01001, 32'h1, 32'h1F);
    check("shl31", zlo_mon, 32'h80000000);
    run_alu(5'b01011, 32'h80000001, 32'h4);
    check("rol4", zlo_mon, 32'h00000018);
    run_alu(5'b01010, 32'h12345678, 32'h20);
    check("ror0", zlo_mon, 32'h12345678);
    run_alu(5'b01011, 32'h12345678, 32'h0);
    check("rol0", zlo_mon, 32'h12345678);
    run_alu(5'b01000, 32'h80000000, 32'h1F);
    check("shra31", zlo_mon, 32'hFFFFFFFF);
    run_alu(5'b10001, 32'h0, 32'h1);
    check("neg", zlo_mon, 32'hFFFFFFFF);
    run_alu(5'b10010, 32'h0, 32'h0F0F0F0F);
    check("not", zlo_mon, 32'hF0F0F0F0);
    run_alu(5'b11111, 32'h0, 32'hFFFFFFFF);
    check("inc_wrap", zlo_mon, 32'h0);
    run_alu(5'b01111, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_alu(5'b00000, 32'h5, 32'h6);
    check("bad_op_hi", zhi_mon, 32'h0);
    check("bad_op_lo", zlo_mon, 32'h0);

    // Bus priority
    load_reg(1, 32'h18);
    load_reg(4, 32'h5);
    r_out[1] = 1'b1; r_out[4] = 1'b1;
    #1 check("prio_r1_r4", BusOut, 32'h18);
    idle();
    #1 check("bus_none", BusOut, 32'h0);
    load_y(32'h55);
    set_mdr(32'h66);
    MDRout = 1'b1; Yout = 1'b1;
    #1 check("prio_mdr_y", BusOut, 32'h66);
    r_out[15] = 1'b1; HIOut = 1'b1;
    #1 check("prio_r15_hi", BusOut, 32'h0);
    idle();

    // Self-load: R4 drives bus and loads R6 and itself from it in one edge
    r_out[4] = 1'b1; r_in[4] = 1'b1; r_in[6] = 1'b1;
    tick(); idle();
    check("self_r4", r_mon[4], 32'h5);
    check("copy_r6", r_mon[6], 32'h5);

    // Fill special registers, then clear overrides loads
    set_mdr(32'h77);
    MDRout = 1'b1; InPC = 1'b1; HIin = 1'b1; LOin = 1'b1; InPortin = 1'b1;
    tick(); idle();
    check("pc_load", pc_mon, 32'h77);
    check("hi_load", hi_mon, 32'h77);
    check("lo_load", lo_mon, 32'h77);
    check("inport_load", inport_mon, 32'h77);
    run_alu(5'b01111, 32'hFFFFFFFF, 32'h3);
    r_out[1] = 1'b1;
    r_in = 16'hFFFF; HIin = 1; LOin = 1; ZHighin = 1; Zlowin = 1; InPC = 1; InPortin = 1; Yin = 1;
    MDRin = 1; Read = 1; Mdatain = 32'hDEADBEEF;
    clear = 1'b0;
    #1 check("bus_during_clear", BusOut, 32'h18);
    tick();
    clear = 1'b1;
    idle();
    for (int i = 0; i < 16; i++) check($sformatf("clr_r%0d", i), r_mon[i], 32'h0);
    check("clr_zhigh", zhi_mon, 32'h0);
    check("clr_zlow", zlo_mon, 32'h0);
    check("clr_pc", pc_mon, 32'h0);
    check("clr_inport", inport_mon, 32'h0);
    check("clr_y", y_mon, 32'h0);
    check("clr_hi", hi_mon, 32'h0);
    check("clr_lo", lo_mon, 32'h0);
    check("clr_mdr", mdrData, 32'h0);
    r_out[1] = 1'b1;
    #1 check("clr_bus", BusOut, 32'h0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
